// File: rtl/gpu_barrier_ctrl.sv
// gpu_barrier_ctrl: per-ID warp barrier tracker driving the scheduler's barrier-stall mask.
// Define BARRIER_PERF_EN to add the stall-cycle and release performance counters.
module gpu_barrier_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 barrier_valid,
    input  logic [NW_BITS-1:0]   barrier_wid,
    input  logic [NB_BITS-1:0]   barrier_id,
    input  logic [NW_BITS-1:0]   barrier_size_m1,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_wmask
`ifdef BARRIER_PERF_EN
   ,output logic [63:0]          perf_barrier_stalls,
    output logic [31:0]          perf_barrier_releases
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]           state_q [NUM_BARRIERS];
    logic [NW_BITS-1:0]   count_q [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
    logic [0:0]           state_d [NUM_BARRIERS];
    logic [NW_BITS-1:0]   count_d [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] stall_d;
    logic [NUM_WARPS-1:0] wid_bit;
    logic [NUM_WARPS-1:0] cur_mask;
    logic [NW_BITS-1:0]   cur_count;
    logic [NW_BITS-1:0]   cur_size;
    logic                 cur_wait;
    logic                 wid_ok;
    logic                 id_ok;
    logic                 stalled;
    logic                 accept;
    logic                 done;

    assign wid_ok    = int'(barrier_wid) < NUM_WARPS;
    assign id_ok     = int'(barrier_id) < NUM_BARRIERS;
    assign cur_wait  = id_ok && (state_q[barrier_id] == WAIT);
    assign cur_count = id_ok ? count_q[barrier_id] : '0;
    assign cur_size  = id_ok ? size_q[barrier_id] : '0;
    assign cur_mask  = id_ok ? wmask_q[barrier_id] : '0;
    assign stalled   = |(stall_mask & wid_bit);
    // A warp already held at any barrier cannot arrive again until it is released.
    assign accept    = barrier_valid && wid_ok && id_ok && !stalled;
    assign done      = accept && (cur_wait ? (cur_count == cur_size) : (barrier_size_m1 == '0));

    always_comb begin
        wid_bit = '0;
        if (wid_ok)
            wid_bit[barrier_wid] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        size_d  = size_q;
        wmask_d = wmask_q;
        stall_d = '0;
        if (accept) begin
            state_d[barrier_id] = done ? IDLE : WAIT;
            count_d[barrier_id] = done ? '0 : (cur_wait ? cur_count + NW_BITS'(1) : NW_BITS'(1));
            size_d[barrier_id]  = cur_wait ? cur_size : barrier_size_m1;
            wmask_d[barrier_id] = done ? '0 : (cur_mask | wid_bit);
        end
        for (int b = 0; b < NUM_BARRIERS; b++)
            stall_d = stall_d | wmask_d[b];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= IDLE;
                count_q[b] <= '0;
                size_q[b]  <= '0;
                wmask_q[b] <= '0;
            end
            stall_mask    <= '0;
            release_valid <= 1'b0;
            release_id    <= '0;
            release_wmask <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            size_q        <= size_d;
            wmask_q       <= wmask_d;
            stall_mask    <= stall_d;
            release_valid <= done;
            if (done) begin
                release_id    <= barrier_id;
                release_wmask <= cur_mask | wid_bit;
            end
        end
    end

`ifdef BARRIER_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_barrier_stalls   <= '0;
            perf_barrier_releases <= '0;
        end else begin
            perf_barrier_stalls   <= perf_barrier_stalls + 64'($countones(stall_mask));
            perf_barrier_releases <= perf_barrier_releases + 32'(release_valid);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!reset_n) barrier_valid |-> !stalled)
        else $warning("gpu_barrier_ctrl: request from held warp %0d ignored", barrier_wid);
    assert property (@(posedge clk) disable iff (!reset_n)
                     (barrier_valid && !stalled && cur_wait) |-> (barrier_size_m1 == cur_size))
        else $warning("gpu_barrier_ctrl: size_m1 %0d differs from latched %0d", barrier_size_m1, cur_size);

endmodule

// File: tb/tb_gpu_barrier_ctrl.sv
// tb_gpu_barrier_ctrl: directed vector table, corner sequences and randomized traffic
// checked against a queue-based barrier model.
module tb_gpu_barrier_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       barrier_valid = 1'b0;
    logic [1:0] barrier_wid = '0;
    logic [1:0] barrier_id = '0;
    logic [1:0] barrier_size_m1 = '0;
    logic [3:0] stall_mask;
    logic       release_valid;
    logic [1:0] release_id;
    logic [3:0] release_wmask;
`ifdef BARRIER_PERF_EN
    logic [63:0] perf_barrier_stalls;
    logic [31:0] perf_barrier_releases;
`endif

    typedef struct {
        logic       v;
        logic [1:0] w;
        logic [1:0] id;
        logic [1:0] sz;
        logic [3:0] stall;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rwm;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int q [4][$];
    int target [4];
    logic [3:0] exp_stall;
    logic       exp_rv;
    logic [1:0] exp_rid;
    logic [3:0] exp_rwm;
    longint unsigned exp_perf_stalls;
    int unsigned     exp_perf_rel;

    always #5 clk = ~clk;

    gpu_barrier_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .barrier_valid(barrier_valid),
        .barrier_wid(barrier_wid),
        .barrier_id(barrier_id),
        .barrier_size_m1(barrier_size_m1),
        .stall_mask(stall_mask),
        .release_valid(release_valid),
        .release_id(release_id),
        .release_wmask(release_wmask)
`ifdef BARRIER_PERF_EN
       ,.perf_barrier_stalls(perf_barrier_stalls),
        .perf_barrier_releases(perf_barrier_releases)
`endif
    );

    function automatic bit held(int w);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < q[b].size(); i++)
                if (q[b][i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] members(int b);
        logic [3:0] m = '0;
        for (int i = 0; i < q[b].size(); i++) m[q[b][i]] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) q[b].delete();
        exp_stall = '0;
        exp_rv = 1'b0;
        exp_rid = '0;
        exp_rwm = '0;
        exp_perf_stalls = 0;
        exp_perf_rel = 0;
    endtask

    // A barrier completes when the number of distinct arrivals reaches size_m1+1.
    task automatic model_step(bit v, int w, int id, int sz);
        exp_perf_stalls += 64'($countones(exp_stall));
        exp_perf_rel += 32'(exp_rv);
        exp_rv = 1'b0;
        if (v && !held(w)) begin
            if (q[id].size() == 0) target[id] = sz + 1;
            q[id].push_back(w);
            if (q[id].size() == target[id]) begin
                exp_rv = 1'b1;
                exp_rid = 2'(id);
                exp_rwm = members(id);
                q[id].delete();
            end
        end
        exp_stall = '0;
        for (int b = 0; b < 4; b++) exp_stall = exp_stall | members(b);
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(bit v, int w, int id, int sz);
        barrier_valid = v;
        barrier_wid = 2'(w);
        barrier_id = 2'(id);
        barrier_size_m1 = 2'(sz);
        model_step(v, w, id, sz);
        @(posedge clk);
        #1;
        barrier_valid = 1'b0;
    endtask

    task automatic check_model(string tag);
        chk({tag, " stall_mask"}, 64'(stall_mask), 64'(exp_stall));
        chk({tag, " release_valid"}, 64'(release_valid), 64'(exp_rv));
        chk({tag, " release_id"}, 64'(release_id), 64'(exp_rid));
        chk({tag, " release_wmask"}, 64'(release_wmask), 64'(exp_rwm));
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("async reset stall_mask", 64'(stall_mask), 64'd0);
        chk("async reset release_valid", 64'(release_valid), 64'd0);
        chk("async reset release_id", 64'(release_id), 64'd0);
        chk("async reset release_wmask", 64'(release_wmask), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t tbl [$];
    int avail [$];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset_n = 1'b1;

        tbl.push_back('{1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000});
        tbl.push_back('{1'b1, 2'd2, 2'd1, 2'd0, 4'b0000, 1'b1, 2'd1, 4'b0100});
        tbl.push_back('{1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd1, 4'b0100});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 2'd2, 4'b0001, 1'b0, 2'd1, 4'b0100});
        tbl.push_back('{1'b1, 2'd1, 2'd0, 2'd2, 4'b0011, 1'b0, 2'd1, 4'b0100});
        tbl.push_back('{1'b1, 2'd2, 2'd0, 2'd2, 4'b0000, 1'b1, 2'd0, 4'b0111});
        tbl.push_back('{1'b1, 2'd0, 2'd0, 2'd1, 4'b0001, 1'b0, 2'd0, 4'b0111});
        tbl.push_back('{1'b1, 2'd1, 2'd3, 2'd1, 4'b0011, 1'b0, 2'd0, 4'b0111});
        tbl.push_back('{1'b1, 2'd2, 2'd0, 2'd1, 4'b0010, 1'b1, 2'd0, 4'b0101});
        tbl.push_back('{1'b1, 2'd3, 2'd3, 2'd1, 4'b0000, 1'b1, 2'd3, 4'b1010});
        tbl.push_back('{1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd3, 4'b1010});
        tbl.push_back('{1'b1, 2'd0, 2'd2, 2'd1, 4'b0001, 1'b0, 2'd3, 4'b1010});
        tbl.push_back('{1'b1, 2'd1, 2'd2, 2'd1, 4'b0000, 1'b1, 2'd2, 4'b0011});
        tbl.push_back('{1'b1, 2'd3, 2'd2, 2'd0, 4'b0000, 1'b1, 2'd2, 4'b1000});
        tbl.push_back('{1'b1, 2'd3, 2'd1, 2'd3, 4'b1000, 1'b0, 2'd2, 4'b1000});
        tbl.push_back('{1'b1, 2'd2, 2'd1, 2'd3, 4'b1100, 1'b0, 2'd2, 4'b1000});
        tbl.push_back('{1'b1, 2'd1, 2'd1, 2'd3, 4'b1110, 1'b0, 2'd2, 4'b1000});
        tbl.push_back('{1'b1, 2'd0, 2'd1, 2'd3, 4'b0000, 1'b1, 2'd1, 4'b1111});
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, int'(tbl[i].w), int'(tbl[i].id), int'(tbl[i].sz));
            chk($sformatf("vec%0d stall_mask", i), 64'(stall_mask), 64'(tbl[i].stall));
            chk($sformatf("vec%0d release_valid", i), 64'(release_valid), 64'(tbl[i].rv));
            chk($sformatf("vec%0d release_id", i), 64'(release_id), 64'(tbl[i].rid));
            chk($sformatf("vec%0d release_wmask", i), 64'(release_wmask), 64'(tbl[i].rwm));
        end

        cycle(1, 0, 0, 2);
        cycle(1, 1, 0, 2);
        chk("midwait stall_mask", 64'(stall_mask), 64'h3);
        async_reset();
        cycle(1, 2, 0, 1);
        chk("post-reset single stall_mask", 64'(stall_mask), 64'h4);
        chk("post-reset single release_valid", 64'(release_valid), 64'd0);
        repeat (3) begin
            cycle(0, 0, 0, 0);
            chk("post-reset idle release_valid", 64'(release_valid), 64'd0);
        end
        cycle(1, 3, 0, 1);
        chk("post-reset complete release_valid", 64'(release_valid), 64'd1);
        chk("post-reset complete release_wmask", 64'(release_wmask), 64'hc);
        chk("post-reset complete stall_mask", 64'(stall_mask), 64'd0);

        cycle(1, 1, 0, 2);
        cycle(1, 1, 0, 2);
        chk("repeat stall_mask", 64'(stall_mask), 64'h2);
        chk("repeat release_valid", 64'(release_valid), 64'd0);
        cycle(1, 1, 3, 0);
        chk("held warp other id release_valid", 64'(release_valid), 64'd0);
        cycle(1, 0, 0, 2);
        chk("second arrival stall_mask", 64'(stall_mask), 64'h3);
        chk("second arrival release_valid", 64'(release_valid), 64'd0);
        cycle(1, 2, 0, 2);
        chk("distinct final release_valid", 64'(release_valid), 64'd1);
        chk("distinct final release_wmask", 64'(release_wmask), 64'h7);
        chk("distinct final stall_mask", 64'(stall_mask), 64'd0);
        check_model("directed end");

        for (int n = 0; n < 600; n++) begin
            avail.delete();
            for (int w = 0; w < 4; w++) if (!held(w)) avail.push_back(w);
            if (avail.size() == 0 || $urandom_range(99) < 2) begin
                async_reset();
            end else if ($urandom_range(99) < 70) begin
                int w, id, sz;
                w = avail[$urandom_range(avail.size() - 1)];
                id = int'($urandom_range(3));
                sz = (q[id].size() != 0) ? target[id] - 1 : int'($urandom_range(3));
                cycle(1, w, id, sz);
            end else begin
                cycle(0, 0, 0, 0);
            end
            check_model($sformatf("rand%0d", n));
        end

`ifdef BARRIER_PERF_EN
        async_reset();
        cycle(1, 0, 0, 2);
        cycle(1, 1, 0, 2);
        repeat (10) cycle(0, 0, 0, 0);
        chk("perf stalls two held", perf_barrier_stalls, 64'd21);
        cycle(1, 2, 0, 2);
        cycle(0, 0, 0, 0);
        chk("perf releases", 64'(perf_barrier_releases), 64'd1);
        chk("perf stalls model", perf_barrier_stalls, exp_perf_stalls);
        chk("perf releases model", 64'(perf_barrier_releases), 64'(exp_perf_rel));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
